// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter
// Shared register bank with a round-robin arbiter between the I2C slave
// register port and the local host port. Every access is serialised through
// a single serve slot (IDLE -> SERVE -> ACK), so the two ports can never
// touch the bank in the same cycle.
//
// Ports:
//   clk_i, reset_i               clock (rising edge), async active-low reset
//   i2c_req_i/we_i/addr_i/wdata_i  I2C-side request (held until ack)
//   i2c_ack_o, i2c_rdata_o         I2C completion pulse and read data
//   host_req_i/we_i/addr_i/wdata_i host-side request (held until ack)
//   host_ack_o, host_rdata_o       host completion pulse and read data
//   data_o                         whole bank, word k at [8k+7:8k]
//   busy_o                         high while in SERVE or ACK
module i2c_reg_arbiter #(
  parameter int NOF_DATA_WORDS   = 2,
  parameter int NOF_ADDRESS_BITS = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          i2c_req_i,
  input  logic                          i2c_we_i,
  input  logic [NOF_ADDRESS_BITS-1:0]   i2c_addr_i,
  input  logic [7:0]                    i2c_wdata_i,
  output logic                          i2c_ack_o,
  output logic [7:0]                    i2c_rdata_o,
  input  logic                          host_req_i,
  input  logic                          host_we_i,
  input  logic [NOF_ADDRESS_BITS-1:0]   host_addr_i,
  input  logic [7:0]                    host_wdata_i,
  output logic                          host_ack_o,
  output logic [7:0]                    host_rdata_o,
  output logic [8*NOF_DATA_WORDS-1:0]   data_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic GRANT_I2C  = 1'b0;
  localparam logic GRANT_HOST = 1'b1;

  state_t                        state_r;
  state_t                        state_next_s;
  logic                          start_s;
  logic                          winner_s;
  logic                          grant_r;
  logic                          last_grant_r;
  logic                          we_r;
  logic [NOF_ADDRESS_BITS-1:0]   addr_r;
  logic [7:0]                    wdata_r;
  logic [7:0]                    rd_word_s;
  logic [7:0]                    bank_r [NOF_DATA_WORDS];
  logic                          i2c_ack_r;
  logic                          host_ack_r;
  logic [7:0]                    i2c_rdata_r;
  logic [7:0]                    host_rdata_r;
  logic                          busy_r;

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and arbitration: on a tie the port that was not granted last wins.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    winner_s     = GRANT_I2C;
    case (state_r)
      IDLE: begin
        if (i2c_req_i && host_req_i) begin
          start_s      = 1'b1;
          winner_s     = (last_grant_r == GRANT_HOST) ? GRANT_I2C : GRANT_HOST;
          state_next_s = SERVE;
        end else if (i2c_req_i) begin
          start_s      = 1'b1;
          winner_s     = GRANT_I2C;
          state_next_s = SERVE;
        end else if (host_req_i) begin
          start_s      = 1'b1;
          winner_s     = GRANT_HOST;
          state_next_s = SERVE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SERVE:   state_next_s = ACK;
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Read mux; addresses with no backing word read as zero.
  always_comb begin
    rd_word_s = 8'h00;
    for (int k = 0; k < NOF_DATA_WORDS; k++) begin
      if (addr_r == NOF_ADDRESS_BITS'(k)) begin
        rd_word_s = bank_r[k];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  // Register bank; out-of-range writes match no word and are dropped.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < NOF_DATA_WORDS; k++) begin
        bank_r[k] <= 8'h00;
      end
    end else if ((state_r == SERVE) && we_r) begin
      for (int k = 0; k < NOF_DATA_WORDS; k++) begin
        if (addr_r == NOF_ADDRESS_BITS'(k)) begin
          bank_r[k] <= wdata_r;
        end
      end
    end
  end

  // Transaction latch, grant history, read data, acks and busy flag.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      grant_r      <= GRANT_I2C;
      last_grant_r <= GRANT_HOST;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 8'h00;
      i2c_rdata_r  <= 8'h00;
      host_rdata_r <= 8'h00;
      i2c_ack_r    <= 1'b0;
      host_ack_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (start_s) begin
        grant_r      <= winner_s;
        last_grant_r <= winner_s;
        we_r         <= (winner_s == GRANT_HOST) ? host_we_i    : i2c_we_i;
        addr_r       <= (winner_s == GRANT_HOST) ? host_addr_i  : i2c_addr_i;
        wdata_r      <= (winner_s == GRANT_HOST) ? host_wdata_i : i2c_wdata_i;
      end
      if ((state_r == SERVE) && !we_r) begin
        if (grant_r == GRANT_HOST) begin
          host_rdata_r <= rd_word_s;
        end else begin
          i2c_rdata_r  <= rd_word_s;
        end
      end
      // Acks are set on leaving SERVE so they are high exactly in ACK.
      i2c_ack_r  <= (state_r == SERVE) && (grant_r == GRANT_I2C);
      host_ack_r <= (state_r == SERVE) && (grant_r == GRANT_HOST);
      busy_r     <= (state_next_s != IDLE);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NOF_DATA_WORDS; g++) begin : g_flat
      assign data_o[8*g +: 8] = bank_r[g];
    end
  endgenerate

  assign i2c_ack_o    = i2c_ack_r;
  assign host_ack_o   = host_ack_r;
  assign i2c_rdata_o  = i2c_rdata_r;
  assign host_rdata_o = host_rdata_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Testbench for i2c_reg_arbiter: directed cases plus randomized rounds
// checked against a transaction-level model (bank array, grant history).
module tb_i2c_reg_arbiter;

  localparam int NW = 2;
  localparam int AW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             i2c_req, i2c_we, i2c_ack;
  logic [AW-1:0]    i2c_addr;
  logic [7:0]       i2c_wdata, i2c_rdata;
  logic             host_req, host_we, host_ack;
  logic [AW-1:0]    host_addr;
  logic [7:0]       host_wdata, host_rdata;
  logic [8*NW-1:0]  data;
  logic             busy;

  // single-word instance for out-of-range checks
  logic             d1_req, d1_we, d1_ack, d1_hack, d1_busy;
  logic [0:0]       d1_addr;
  logic [7:0]       d1_wdata, d1_rdata, d1_hrdata, d1_data;
  logic             d1_hreq   = 1'b0;
  logic             d1_hwe    = 1'b0;
  logic [0:0]       d1_haddr  = 1'b0;
  logic [7:0]       d1_hwdata = 8'h00;

  i2c_reg_arbiter #(.NOF_DATA_WORDS(NW), .NOF_ADDRESS_BITS(AW)) dut (
    .clk_i(clk), .reset_i(rst_n),
    .i2c_req_i(i2c_req), .i2c_we_i(i2c_we), .i2c_addr_i(i2c_addr),
    .i2c_wdata_i(i2c_wdata), .i2c_ack_o(i2c_ack), .i2c_rdata_o(i2c_rdata),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_ack_o(host_ack), .host_rdata_o(host_rdata),
    .data_o(data), .busy_o(busy)
  );

  i2c_reg_arbiter #(.NOF_DATA_WORDS(1), .NOF_ADDRESS_BITS(1)) dut1 (
    .clk_i(clk), .reset_i(rst_n),
    .i2c_req_i(d1_req), .i2c_we_i(d1_we), .i2c_addr_i(d1_addr),
    .i2c_wdata_i(d1_wdata), .i2c_ack_o(d1_ack), .i2c_rdata_o(d1_rdata),
    .host_req_i(d1_hreq), .host_we_i(d1_hwe), .host_addr_i(d1_haddr),
    .host_wdata_i(d1_hwdata), .host_ack_o(d1_hack), .host_rdata_o(d1_hrdata),
    .data_o(d1_data), .busy_o(d1_busy)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_bank [NW];
  logic       m_last;              // 0 = I2C, 1 = HOST
  logic [7:0] m_rd_i2c, m_rd_host;

  task automatic model_reset();
    for (int k = 0; k < NW; k++) m_bank[k] = 8'h00;
    m_last    = 1'b1;
    m_rd_i2c  = 8'h00;
    m_rd_host = 8'h00;
  endtask

  function automatic logic [8*NW-1:0] model_flat();
    logic [8*NW-1:0] r;
    for (int k = 0; k < NW; k++) r[8*k +: 8] = m_bank[k];
    return r;
  endfunction

  task automatic model_apply(input logic port, input logic we, input int addr, input logic [7:0] wd);
    logic [7:0] v;
    m_last = port;
    if (we) begin
      if (addr < NW) m_bank[addr] = wd;
    end else begin
      v = (addr < NW) ? m_bank[addr] : 8'h00;
      if (port) m_rd_host = v;
      else      m_rd_i2c  = v;
    end
  endtask

  // One round: I2C issues ni identical transactions back to back, host nh.
  task automatic do_round(input int ni, input logic iwe, input logic [AW-1:0] iaddr,
                          input logic [7:0] iwd, input int nh, input logic hwe,
                          input logic [AW-1:0] haddr, input logic [7:0] hwd);
    int   sched[$];
    int   ri, rh, n, w;
    logic lg, exp_i, exp_h, exp_busy;
    ri = ni; rh = nh; lg = m_last;
    while (ri > 0 || rh > 0) begin
      if (ri > 0 && rh > 0) w = (lg == 1'b1) ? 0 : 1;
      else if (ri > 0)      w = 0;
      else                  w = 1;
      sched.push_back(w);
      lg = (w == 1);
      if (w == 0) ri--; else rh--;
    end
    n = sched.size(); ri = ni; rh = nh;
    @(posedge clk); #1;
    i2c_req  = (ni > 0); i2c_we  = iwe; i2c_addr  = iaddr; i2c_wdata  = iwd;
    host_req = (nh > 0); host_we = hwe; host_addr = haddr; host_wdata = hwd;
    for (int k = 1; k <= 3*n + 1; k++) begin
      @(negedge clk);
      exp_i = 1'b0; exp_h = 1'b0;
      if (k % 3 == 0) begin
        if (sched[k/3 - 1] == 0) exp_i = 1'b1;
        else                     exp_h = 1'b1;
      end
      exp_busy = (k <= 3*n) && (k % 3 != 1);
      check_value("i2c_ack", 32'(i2c_ack), 32'(exp_i));
      check_value("host_ack", 32'(host_ack), 32'(exp_h));
      check_value("busy", 32'(busy), 32'(exp_busy));
      if (exp_i) begin
        model_apply(1'b0, iwe, int'(iaddr), iwd);
        ri--;
        if (ri == 0) i2c_req = 1'b0;
      end
      if (exp_h) begin
        model_apply(1'b1, hwe, int'(haddr), hwd);
        rh--;
        if (rh == 0) host_req = 1'b0;
      end
      if (exp_i || exp_h) begin
        check_value("i2c_rdata", 32'(i2c_rdata), 32'(m_rd_i2c));
        check_value("host_rdata", 32'(host_rdata), 32'(m_rd_host));
        check_value("data", 32'(data), 32'(model_flat()));
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i2c_req = 1'b0; host_req = 1'b0; d1_req = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_value("rst_data", 32'(data), 32'h0000);
      check_value("rst_i2c_ack", 32'(i2c_ack), 32'h0);
      check_value("rst_host_ack", 32'(host_ack), 32'h0);
      check_value("rst_busy", 32'(busy), 32'h0);
    end
    check_value("rst_i2c_rdata", 32'(i2c_rdata), 32'h00);
    check_value("rst_host_rdata", 32'(host_rdata), 32'h00);
  endtask

  task automatic d1_txn(input logic we, input logic [0:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_data, input logic [7:0] exp_rd);
    @(posedge clk); #1;
    d1_req = 1'b1; d1_we = we; d1_addr = addr; d1_wdata = wd;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_value("d1_ack", 32'(d1_ack), 32'(k == 3));
      check_value("d1_host_ack", 32'(d1_hack), 32'h0);
      if (k == 3) begin
        d1_req = 1'b0;
        check_value("d1_data", 32'(d1_data), 32'(exp_data));
        check_value("d1_rdata", 32'(d1_rdata), 32'(exp_rd));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i2c_req = 1'b0; i2c_we = 1'b0; i2c_addr = '0; i2c_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 8'h00;
    d1_req = 1'b0; d1_we = 1'b0; d1_addr = 1'b0; d1_wdata = 8'h00;
    model_reset();
    apply_reset();

    // tie from reset: I2C first, then strict alternation
    do_round(2, 1'b1, 1'b0, 8'h11, 2, 1'b1, 1'b0, 8'h22);
    check_value("fair_word0", 32'(data[7:0]), 32'h22);
    apply_reset();

    // directed writes and reads
    do_round(1, 1'b1, 1'b1, 8'hA5, 0, 1'b0, 1'b0, 8'h00);
    check_value("dir_a500", 32'(data), 32'hA500);
    do_round(0, 1'b0, 1'b0, 8'h00, 1, 1'b1, 1'b0, 8'h3C);
    do_round(0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b1, 8'h00);
    check_value("dir_a53c", 32'(data), 32'hA53C);
    check_value("dir_host_rd", 32'(host_rdata), 32'hA5);
    check_value("dir_i2c_rd", 32'(i2c_rdata), 32'h00);

    // randomized rounds
    for (int r = 0; r < 60; r++) begin
      do_round(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, (1 << AW) - 1)), 8'($urandom),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, (1 << AW) - 1)), 8'($urandom));
    end

    // reset asserted during SERVE of a write
    apply_reset();
    @(posedge clk); #1;
    i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 1'b0; i2c_wdata = 8'h77;
    @(negedge clk);
    @(negedge clk);
    check_value("mid_busy_serve", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_value("mid_data", 32'(data), 32'h0000);
    check_value("mid_busy", 32'(busy), 32'h0);
    i2c_req = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_value("mid_ack_rst", 32'(i2c_ack), 32'h0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_value("mid_ack_post", 32'(i2c_ack), 32'h0);
      check_value("mid_data_post", 32'(data), 32'h0000);
      check_value("mid_busy_post", 32'(busy), 32'h0);
    end
    do_round(1, 1'b1, 1'b0, 8'h77, 0, 1'b0, 1'b0, 8'h00);
    check_value("mid_after", 32'(data), 32'h0077);

    // single-word bank: out-of-range write dropped, read returns zero
    d1_txn(1'b1, 1'b0, 8'h5A, 8'h5A, 8'h00);
    d1_txn(1'b1, 1'b1, 8'hFF, 8'h5A, 8'h00);
    d1_txn(1'b0, 1'b0, 8'h00, 8'h5A, 8'h5A);
    d1_txn(1'b0, 1'b1, 8'h00, 8'h5A, 8'h00);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
